// File: rtl/pc_sequencer_pkg.sv
// Shared sequencing definitions: PC width, command encoding and command priority.
package pc_sequencer_pkg;

  localparam int unsigned PC_WIDTH = 8;

  typedef enum logic [2:0] {
    SEQ_INC,
    SEQ_JMP,
    SEQ_JZ,
    SEQ_CALL,
    SEQ_RET
  } seq_cmd_e;

  // Highest priority first; stall sits above all of these and is handled by the caller.
  localparam seq_cmd_e SEQ_PRIORITY [5] = '{SEQ_RET, SEQ_CALL, SEQ_JMP, SEQ_JZ, SEQ_INC};

  function automatic seq_cmd_e seq_decode(input logic ret, input logic call, input logic jmp,
                                          input logic jz);
    logic [4:0] req;
    seq_cmd_e   sel;
    req           = '0;
    req[SEQ_RET]  = ret;
    req[SEQ_CALL] = call;
    req[SEQ_JMP]  = jmp;
    req[SEQ_JZ]   = jz;
    req[SEQ_INC]  = 1'b1;
    sel           = SEQ_INC;
    for (int i = 4; i >= 0; i--) begin
      if (req[SEQ_PRIORITY[i]]) sel = SEQ_PRIORITY[i];
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO with count, full/empty flags and overflow/underflow pulses.
module ret_stack #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [CntW-1:0]  count_q, count_d, top_cnt;
  logic             do_push, do_pop;

  assign full_o      = (count_q == CntW'(Depth));
  assign empty_o     = (count_q == '0);
  assign do_push     = push_i && !full_o;
  // Push wins if both are requested, so a pop is only seen without a push.
  assign do_pop      = pop_i && !push_i && !empty_o;
  assign overflow_o  = push_i && full_o;
  assign underflow_o = pop_i && !push_i && empty_o;
  assign top_cnt     = count_q - CntW'(1);
  assign data_o      = empty_o ? '0 : mem_q[top_cnt[IdxW-1:0]];
  assign count_o     = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop) begin
      count_d = top_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[count_q[IdxW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with jump/branch/call/return sequencing and a hardware return stack.
// Define PC_HALT_ON_ERR_EN to freeze the PC on stack overflow/underflow until reset.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = pc_sequencer_pkg::PC_WIDTH,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                jmp,
  input  logic                jz,
  input  logic                call,
  input  logic                ret,
  input  logic                zero_flag,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] instr_addr,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                stack_err,
  output logic                halted
);

  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, stk_data;
  logic [CntW-1:0]     stk_count;
  logic                stk_full, stk_empty, stk_ovf, stk_unf;
  logic                push, pop, err_set, err_q, frozen;
  seq_cmd_e            cmd;

  assign err_set = stk_ovf || stk_unf;

`ifdef PC_HALT_ON_ERR_EN
  localparam bit HoldOnErr = 1'b1;
  logic halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (err_set) begin
      halted_q <= 1'b1;
    end
  end

  assign frozen = halted_q;
  assign halted = halted_q;
`else
  localparam bit HoldOnErr = 1'b0;
  assign frozen = 1'b0;
  assign halted = 1'b0;
`endif

  always_comb begin
    pc_inc = pc_q + PC_WIDTH'(1);
    pc_d   = pc_q;
    push   = 1'b0;
    pop    = 1'b0;
    cmd    = seq_decode(ret, call, jmp, jz);
    if (!stall && !frozen) begin
      unique case (cmd)
        SEQ_RET: begin
          pop  = 1'b1;
          pc_d = stk_empty ? (HoldOnErr ? pc_q : pc_inc) : stk_data;
        end
        SEQ_CALL: begin
          push = 1'b1;
          pc_d = (HoldOnErr && stk_full) ? pc_q : target;
        end
        SEQ_JMP: pc_d = target;
        SEQ_JZ:  pc_d = zero_flag ? target : pc_inc;
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_q || err_set;
    end
  end

  ret_stack #(
    .Width(PC_WIDTH),
    .Depth(STACK_DEPTH)
  ) u_ret_stack (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push),
    .pop_i      (pop),
    .data_i     (pc_inc),
    .data_o     (stk_data),
    .count_o    (stk_count),
    .full_o     (stk_full),
    .empty_o    (stk_empty),
    .overflow_o (stk_ovf),
    .underflow_o(stk_unf)
  );

  assign instr_addr  = pc_q;
  assign stack_full  = (stk_count == CntW'(STACK_DEPTH));
  assign stack_empty = (stk_count == '0);
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a queue-based sequencing model.
module tb_pc_sequencer;

  localparam int W = 8;
  localparam int D = 8;
`ifdef PC_HALT_ON_ERR_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, stall, jmp, jz, call, ret, zero_flag;
  logic [W-1:0] target;
  logic [W-1:0] instr_addr;
  logic         stack_full, stack_empty, stack_err, halted;

  int checks = 0;
  int failures = 0;

  int m_pc;
  int m_stk[$];
  bit m_err, m_halt;

  pc_sequencer #(
    .PC_WIDTH(W),
    .STACK_DEPTH(D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .jmp        (jmp),
    .jz         (jz),
    .call       (call),
    .ret        (ret),
    .zero_flag  (zero_flag),
    .target     (target),
    .instr_addr (instr_addr),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sequencing rules applied to the inputs sampled at the edge just taken.
  task automatic model_step();
    if (rst) begin
      m_pc = 0;
      m_stk.delete();
      m_err = 0;
      m_halt = 0;
    end else if (stall || m_halt) begin
      m_pc = m_pc;
    end else if (ret) begin
      if (m_stk.size() == 0) begin
        m_err = 1;
        if (HALT) m_halt = 1;
        else m_pc = (m_pc + 1) % 256;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (call) begin
      if (m_stk.size() == D) begin
        m_err = 1;
        if (HALT) m_halt = 1;
        else m_pc = target;
      end else begin
        m_stk.push_back((m_pc + 1) % 256);
        m_pc = target;
      end
    end else if (jmp || (jz && zero_flag)) begin
      m_pc = target;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic step(input string tag, input logic r, input logic st, input logic c,
                      input logic rt, input logic j, input logic z, input logic zf,
                      input logic [W-1:0] tgt);
    rst = r; stall = st; call = c; ret = rt; jmp = j; jz = z; zero_flag = zf; target = tgt;
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".pc"},    instr_addr,  m_pc);
    chk({tag, ".full"},  stack_full,  m_stk.size() == D);
    chk({tag, ".empty"}, stack_empty, m_stk.size() == 0);
    chk({tag, ".err"},   stack_err,   m_err);
    chk({tag, ".halt"},  halted,      m_halt);
  endtask

  task automatic do_rst();                  step("rst",  1, 0, 0, 0, 0, 0, 0, 8'h00); endtask
  task automatic do_idle();                 step("idle", 0, 0, 0, 0, 0, 0, 0, 8'h00); endtask
  task automatic do_call(input logic [W-1:0] t); step("call", 0, 0, 1, 0, 0, 0, 0, t); endtask
  task automatic do_ret();                  step("ret",  0, 0, 0, 1, 0, 0, 0, 8'h00); endtask
  task automatic do_jmp(input logic [W-1:0] t);  step("jmp",  0, 0, 0, 0, 1, 0, 0, t); endtask

  initial begin
    int exp_ret[8];

    // Reset and free-running increment.
    do_rst();
    chk("rst_pc", instr_addr, 0);
    chk("rst_empty", stack_empty, 1);
    chk("rst_err", stack_err, 0);
    for (int i = 1; i <= 5; i++) begin
      do_idle();
      chk("idle_pc", instr_addr, i);
    end

    // Single call/return.
    do_jmp(8'h10);
    do_call(8'h40);
    chk("call_pc", instr_addr, 8'h40);
    do_ret();
    chk("ret_pc", instr_addr, 8'h11);
    chk("ret_empty", stack_empty, 1);

    // Nested calls across the full depth return in reverse order.
    do_rst();
    for (int i = 0; i < 8; i++) begin
      exp_ret[i] = (i == 0) ? 8'h01 : 8'h42 + 8'h10 * (i - 1);
      do_call(8'(8'h40 + 8'h10 * i));
      if (i < 7) do_idle();
    end
    chk("nest_full", stack_full, 1);
    for (int j = 7; j >= 0; j--) begin
      do_ret();
      chk("nest_ret", instr_addr, exp_ret[j]);
    end
    chk("nest_empty", stack_empty, 1);

    // Overflow on the ninth call.
    do_rst();
    for (int i = 0; i < 8; i++) do_call(8'h60);
    do_call(8'hC5);
    chk("ovf_err", stack_err, 1);
    chk("ovf_pc", instr_addr, HALT ? 8'h60 : 8'hC5);
    chk("ovf_halt", halted, HALT);
    do_jmp(8'h12);
    chk("ovf_after", instr_addr, HALT ? 8'h60 : 8'h12);

    // Conditional branch and wrap.
    do_rst();
    do_jmp(8'h05);
    step("jz0", 0, 0, 0, 0, 0, 1, 0, 8'h20);
    chk("jz0_pc", instr_addr, 8'h06);
    step("jz1", 0, 0, 0, 0, 0, 1, 1, 8'h20);
    chk("jz1_pc", instr_addr, 8'h20);
    do_jmp(8'hFF);
    do_idle();
    chk("wrap_pc", instr_addr, 8'h00);

    // Priority: ret beats call and jmp; stall beats everything.
    do_rst();
    do_jmp(8'h32);
    do_call(8'h70);
    step("prio", 0, 0, 1, 1, 1, 0, 0, 8'h99);
    chk("prio_pc", instr_addr, 8'h33);
    chk("prio_empty", stack_empty, 1);
    for (int i = 0; i < 3; i++) begin
      step("stall", 0, 1, 0, 0, 1, 0, 0, 8'h55);
      chk("stall_pc", instr_addr, 8'h33);
    end

    // Underflow, then reset in the middle of a call sequence.
    do_rst();
    do_jmp(8'h07);
    do_ret();
    chk("unf_err", stack_err, 1);
    chk("unf_pc", instr_addr, HALT ? 8'h07 : 8'h08);
    do_call(8'h20);
    do_call(8'h30);
    do_call(8'h40);
    do_rst();
    chk("mid_rst_pc", instr_addr, 0);
    chk("mid_rst_empty", stack_empty, 1);
    chk("mid_rst_err", stack_err, 0);
    chk("mid_rst_halt", halted, 0);

    // Randomized command mix against the model.
    do_rst();
    for (int n = 0; n < 600; n++) begin
      step("rand", $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage sitting directly upstream of control_module. It generates instr_addr every cycle and executes sequencing commands from the control path: increment, jump, jump-if-zero on the ALU zero_flag, call and return. Calls and returns use an internal hardware return-address stack, so the processor datapath needs no memory round-trip for subroutine linkage.

Parameters:
PC_WIDTH, 8, width of instr_addr and return addresses.
STACK_DEPTH, 8, number of return-address entries; must be at least 2.

Ports:
clk  input  1  processor clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hold PC and stack; all commands ignored this cycle.
jmp  input  1  unconditional jump to target.
jz  input  1  jump to target if zero_flag is 1, else increment.
call  input  1  push instr_addr+1, jump to target.
ret  input  1  pop top of stack into instr_addr.
zero_flag  input  1  ALU zero flag, sampled in the same cycle as jz.
target  input  PC_WIDTH  jump/call destination.
instr_addr  output  PC_WIDTH  registered current instruction address.
stack_full  output  1  count == STACK_DEPTH, combinational from count.
stack_empty  output  1  count == 0, combinational from count.
stack_err  output  1  sticky: set on overflow or underflow, cleared only by rst.
halted  output  1  PC frozen by error; constant 0 when the optional feature is absent.

Behaviour:
- Reset (rst=1 at edge): instr_addr=0, count=0, stack_err=0, halted=0. Stack RAM contents are don't-care. Reset overrides every command, including mid-call.
- Latency: a command sampled at edge N updates instr_addr on edge N, visible from cycle N+1. There are no multi-cycle operations.
- Priority when several commands are asserted: stall > ret > call > jmp > jz > increment. Lower-priority commands in the same cycle are ignored entirely; for example, call+ret performs only the ret.
- Increment: instr_addr <= instr_addr+1, modulo 2^PC_WIDTH. 0xFF wraps to 0x00 with no flag.
- jz with zero_flag=0 behaves as increment. With zero_flag=1 it loads target.
- call, not full: stack[count] <= instr_addr+1 (wrapped), count++, instr_addr <= target.
- call, full: overflow. No push, count unchanged, stack_err <= 1, instr_addr <= target.
- ret, not empty: instr_addr <= stack[count-1], count--.
- ret, empty: underflow. stack_err <= 1, instr_addr increments, count stays 0.
- stall=1: instr_addr, count, stack and stack_err all hold.
- The stack is LIFO. Return order must exactly mirror call order across the full depth.

Optional Feature:
Macro PC_HALT_ON_ERR_EN.
- Defined: on the cycle an overflow or underflow is detected, halted <= 1 and instr_addr <= its current value (the offending call/ret does not advance the PC). While halted=1, all commands are ignored as if stall were high, and only rst clears it.
- Not defined: halted is tied 0, and errors follow the Behaviour rules above.

Decomposition:
- Shared package (existing instructions package): PC_WIDTH constant, the sequencing command encoding (typedef enum SEQ_INC, SEQ_JMP, SEQ_JZ, SEQ_CALL, SEQ_RET), and the priority order constant.
- One sub-module, ret_stack: parameterised LIFO with push/pop/data_in/data_out, count, full, empty, overflow and underflow pulses. pc_sequencer holds the PC register, priority decode and error/halt logic.

Test Plan:
1. Reset then 5 idle cycles -> instr_addr 0,1,2,3,4,5; stack_empty=1; stack_err=0.
2. At instr_addr=0x10: call target=0x40; then ret -> instr_addr 0x40, then 0x11; count back to 0.
3. Nested: 8 calls from 0x00,0x41,0x51,... to distinct targets, then 8 rets -> return addresses come back in reverse order; stack_full=1 after the 8th call. A 9th call -> stack_err=1 and instr_addr=target; with PC_HALT_ON_ERR_EN, halted=1 and the PC is frozen.
4. jz target=0x20 with zero_flag=0 at 0x05 -> 0x06; with zero_flag=1 -> 0x20. At instr_addr=0xFF with no command -> 0x00.
5. call+ret+jmp together with one entry holding 0x33 -> instr_addr 0x33, count 0. Then stall=1 with jmp asserted for 3 cycles -> instr_addr unchanged.
6. ret on empty at 0x07 -> stack_err=1, instr_addr 0x08 (macro off). rst asserted mid-sequence after 3 calls -> instr_addr 0, count 0, stack_err 0 on the next cycle.
